// File: rtl/calc_op_scheduler.sv
// calc_op_scheduler: round-robin arbiter sharing one calculator core among N_REQ requesters.
// Define CALC_SCHED_TIMEOUT_EN to add a core-ready watchdog of TIMEOUT_CYCLES WAIT cycles.
module calc_op_scheduler #(
  parameter int N_REQ = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [N_REQ-1:0]      i_req,
  input  logic [3*N_REQ-1:0]    i_req_op,
  input  logic [16*N_REQ-1:0]   i_req_operand,
  output logic [N_REQ-1:0]      o_ack,
  output logic [N_REQ-1:0]      o_rsp_valid,
  output logic [31:0]           o_rsp_result,
  output logic                  o_rsp_err,
  output logic                  o_busy,
  output logic                  o_core_start,
  output logic [2:0]            o_core_operation,
  output logic [15:0]           o_core_operand_a,
  input  logic [31:0]           i_core_result,
  input  logic                  i_core_ready
);
  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t r_state, w_state;
  logic [GW-1:0] r_ptr, r_grant, w_grant;
  logic w_found, w_ready, w_timeout;
  logic [2:0] w_op;
  logic [15:0] w_operand;
  if (N_REQ < 1 || N_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("calc_op_scheduler: N_REQ must be 1..8 and TIMEOUT_CYCLES >= 1");
  end
  // core_start is high only in the first WAIT cycle, where a ready left over from the previous op must be ignored
  assign w_ready = i_core_ready && !o_core_start;
  assign o_busy = r_state != IDLE;
  assign w_op = i_req_op[3*int'(w_grant) +: 3];
  assign w_operand = i_req_operand[16*int'(w_grant) +: 16];
`ifdef CALC_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_wdog;
  assign w_timeout = r_wdog == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk)
    r_wdog <= (!reset_n || r_state != WAIT) ? '0 : r_wdog + 1'b1;
`else
  assign w_timeout = 1'b0;
`endif
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!w_found && i_req[(int'(r_ptr) + k) % N_REQ]) begin
        w_found = 1'b1;
        w_grant = GW'((int'(r_ptr) + k) % N_REQ);
      end
    end
  end
  always_comb begin
    w_state = r_state;
    case (r_state)
      IDLE:    if (w_found) w_state = (w_op > 3'd4) ? RESP : ISSUE;
      ISSUE:   w_state = WAIT;
      WAIT:    if (w_ready || w_timeout) w_state = RESP;
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_ptr <= '0;
      r_grant <= '0;
      o_ack <= '0;
      o_rsp_valid <= '0;
      o_rsp_result <= '0;
      o_rsp_err <= 1'b0;
      o_core_start <= 1'b0;
      o_core_operation <= '0;
      o_core_operand_a <= '0;
    end else begin
      r_state <= w_state;
      o_ack <= '0;
      o_rsp_valid <= '0;
      o_core_start <= r_state == ISSUE;
      if (r_state == IDLE && w_found) begin
        o_ack[w_grant] <= 1'b1;
        r_grant <= w_grant;
        o_core_operation <= w_op;
        o_core_operand_a <= w_operand;
        if (w_op > 3'd4) begin
          o_rsp_result <= '0;
          o_rsp_err <= 1'b1;
        end
      end
      if (r_state == WAIT && (w_ready || w_timeout)) begin
        o_rsp_result <= w_ready ? i_core_result : '1;
        o_rsp_err <= !w_ready;
      end
      if (r_state == RESP) begin
        o_rsp_valid[r_grant] <= 1'b1;
        r_ptr <= GW'((int'(r_grant) + 1) % N_REQ);
      end
    end
  end
endmodule
